// File: rtl/busca_de_instrucao_if.sv
// Fetch bus bundle shared by the fetch unit, the instruction memory and decode.
//   master : fetch unit view (drives pc_mem and the decode-side outputs)
//   slave  : environment view (memory + decode)
// Signals:
//   stall, branch_taken, branch_target : decode -> fetch control
//   instrucao_mem                      : memory read data (registered in memory)
//   pc_mem                             : fetch address to memory
//   instrucao_out, pc_out, valid_out   : instruction presented to decode
//   halted                             : fetch stopped
interface busca_de_instrucao_if #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 16
) ();
  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [INSTR_WIDTH-1:0] instrucao_mem;
  logic [PC_WIDTH-1:0]    pc_mem;
  logic [INSTR_WIDTH-1:0] instrucao_out;
  logic [PC_WIDTH-1:0]    pc_out;
  logic                   valid_out;
  logic                   halted;

  modport master (
    input  stall, branch_taken, branch_target, instrucao_mem,
    output pc_mem, instrucao_out, pc_out, valid_out, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, instrucao_mem,
    input  pc_mem, instrucao_out, pc_out, valid_out, halted
  );
endinterface

// File: rtl/busca_de_instrucao.sv
// Instruction fetch unit. Issues addresses to a synchronous instruction
// memory (data returns one edge later), presents {instruction, pc, valid}
// to decode at one instruction per clock, absorbs decode stalls with a
// one-entry skid buffer, redirects on taken branches and halts at the end
// of the program.
// Ports:
//   clk_BI : fetch clock (rising edge), shared with the instruction memory
//   reset  : asynchronous active-low reset
//   bus    : busca_de_instrucao_if.master (control in, memory bus, decode out)
// Build option:
//   FETCH_WRAP_EN : when defined, the pc wraps from MAX_PC to RESET_PC and an
//                   out-of-range branch target redirects to RESET_PC; halted
//                   is never raised.
module busca_de_instrucao #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0,
  parameter int MAX_PC      = 41
) (
  input  logic                  clk_BI,
  input  logic                  reset,
  busca_de_instrucao_if.master  bus
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] MAX_PC_V   = PC_WIDTH'(MAX_PC);

  logic [PC_WIDTH-1:0]    pc_mem_q;
  logic [INSTR_WIDTH-1:0] instr_out_q;
  logic [PC_WIDTH-1:0]    pc_out_q;
  logic                   valid_q;
  logic                   halted_q;

  // f1: address issued at the previous edge; memory data for it is on
  // instrucao_mem during the current cycle.
  logic                   f1_valid;
  logic [PC_WIDTH-1:0]    f1_pc;

  // Skid entry: holds the word that was in flight when decode stalled.
  logic                   sk_valid;
  logic [INSTR_WIDTH-1:0] sk_instr;
  logic [PC_WIDTH-1:0]    sk_pc;

  always_ff @(posedge clk_BI or negedge reset) begin
    if (!reset) begin
      pc_mem_q    <= RESET_PC_V;
      instr_out_q <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      f1_valid    <= 1'b0;
      f1_pc       <= '0;
      sk_valid    <= 1'b0;
      sk_instr    <= '0;
      sk_pc       <= '0;
    end else if (bus.branch_taken) begin
      // Branch beats stall: everything in flight is wrong-path.
      f1_valid <= 1'b0;
      sk_valid <= 1'b0;
      valid_q  <= 1'b0;
      if (bus.branch_target <= MAX_PC_V) begin
        pc_mem_q <= bus.branch_target;
        halted_q <= 1'b0;
      end else begin
`ifdef FETCH_WRAP_EN
        pc_mem_q <= RESET_PC_V;
        halted_q <= 1'b0;
`else
        halted_q <= 1'b1;
`endif
      end
    end else if (bus.stall) begin
      // Only the first stall edge has a live f1; later edges see f1_valid=0.
      // pc_mem is re-issued on release, so the word in flight now is the
      // only one that needs saving.
      if (f1_valid && !sk_valid) begin
        sk_instr <= bus.instrucao_mem;
        sk_pc    <= f1_pc;
        sk_valid <= 1'b1;
      end
      f1_valid <= 1'b0;
    end else begin
      if (sk_valid) begin
        instr_out_q <= sk_instr;
        pc_out_q    <= sk_pc;
        valid_q     <= 1'b1;
        sk_valid    <= 1'b0;
      end else if (f1_valid) begin
        instr_out_q <= bus.instrucao_mem;
        pc_out_q    <= f1_pc;
        valid_q     <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end

      if (!halted_q) begin
        f1_valid <= 1'b1;
        f1_pc    <= pc_mem_q;
        if (pc_mem_q == MAX_PC_V) begin
`ifdef FETCH_WRAP_EN
          pc_mem_q <= RESET_PC_V;
`else
          halted_q <= 1'b1;
`endif
        end else begin
          pc_mem_q <= pc_mem_q + PC_WIDTH'(1);
        end
      end else begin
        f1_valid <= 1'b0;
      end
    end
  end

  assign bus.pc_mem        = pc_mem_q;
  assign bus.instrucao_out = instr_out_q;
  assign bus.pc_out        = pc_out_q;
  assign bus.valid_out     = valid_q;
  assign bus.halted        = halted_q;

endmodule
